// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM state encoding for the UART command responder.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    EXEC,
    SEND0,
    WAIT0,
    SEND1,
    WAIT1
  } state_e;

endpackage

// File: rtl/uart_cmd_regfile.sv
// NUM_REGS x 8-bit register file: synchronous write, asynchronous read,
// synchronous active-low clear, plus a flat view of every register.
module uart_cmd_regfile #(
  parameter int NUM_REGS = 4,
  parameter int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Wr_En,
  input  logic [AW-1:0]         i_Addr,
  input  logic [7:0]            i_Wr_Data,
  output logic [7:0]            o_Rd_Data,
  output logic [NUM_REGS*8-1:0] o_Regs
);

  logic [7:0] regs_q [NUM_REGS];

  // NOTE: this array is cleared on reset because the host must see zeroed
  // control registers after reset; arrays that are pure storage should not be.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else if (i_Wr_En) begin
      regs_q[i_Addr] <= i_Wr_Data;
    end
  end

  assign o_Rd_Data = regs_q[i_Addr];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign o_Regs[8*k +: 8] = regs_q[k];
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Request/reply engine between uart_rx and uart_tx: parses R/W frames,
// accesses the register file and sequences ACK/NAK/data replies.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int NUM_REGS     = 4,
  parameter int TIMEOUT_CLKS = 104170
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Active,
  input  logic                  i_Tx_Done,
  output logic [NUM_REGS*8-1:0] o_Regs,
  output logic                  o_Busy,
  output logic                  o_Overrun
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          two_q, two_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          overrun_q, overrun_d;
  logic          wr_en;
  logic          tx_dv;
  logic          addr_ok;
  logic [7:0]    rd_data;

  // Full 8-bit compare so out-of-range addresses never alias onto a register.
  assign addr_ok = (32'(addr_q) < NUM_REGS);

  uart_cmd_regfile #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_regfile (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Wr_En   (wr_en),
    .i_Addr    (addr_q[AW-1:0]),
    .i_Wr_Data (data_q),
    .o_Rd_Data (rd_data),
    .o_Regs    (o_Regs)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      two_q     <= 1'b0;
      tcnt_q    <= '0;
      tx_byte_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      two_q     <= two_d;
      tcnt_q    <= tcnt_d;
      tx_byte_q <= tx_byte_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    two_d     = two_q;
    tcnt_d    = '0;
    tx_byte_d = tx_byte_q;
    wr_en     = 1'b0;
    tx_dv     = 1'b0;
    overrun_d = i_Rx_DV && (state_q inside {EXEC, SEND0, WAIT0, SEND1, WAIT1});

    case (state_q)
      IDLE: begin
        if (i_Rx_DV) begin
          cmd_d   = i_Rx_Byte;
          state_d = (i_Rx_Byte == CMD_READ || i_Rx_Byte == CMD_WRITE) ? GET_ADDR : EXEC;
        end
      end
      GET_ADDR: begin
        // A byte arriving in the expiry cycle takes priority over the timeout.
        if (i_Rx_DV) begin
          addr_d  = i_Rx_Byte;
          state_d = (cmd_q == CMD_WRITE) ? GET_DATA : EXEC;
        end else if (tcnt_q == T_LAST) begin
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      GET_DATA: begin
        if (i_Rx_DV) begin
          data_d  = i_Rx_Byte;
          state_d = EXEC;
        end else if (tcnt_q == T_LAST) begin
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      EXEC: begin
        state_d   = SEND0;
        two_d     = 1'b0;
        tx_byte_d = RSP_NAK;
        if (addr_ok && cmd_q == CMD_READ) begin
          tx_byte_d = RSP_ACK;
          data_d    = rd_data;
          two_d     = 1'b1;
        end else if (addr_ok && cmd_q == CMD_WRITE) begin
          tx_byte_d = RSP_ACK;
          wr_en     = 1'b1;
        end
      end
      SEND0: begin
        if (!i_Tx_Active) begin
          tx_dv   = 1'b1;
          state_d = WAIT0;
        end
      end
      WAIT0: begin
        if (i_Tx_Done) begin
          if (two_q) begin
            tx_byte_d = data_q;
            state_d   = SEND1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SEND1: begin
        if (!i_Tx_Active) begin
          tx_dv   = 1'b1;
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        if (i_Tx_Done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_Tx_DV   = tx_dv;
  assign o_Tx_Byte = tx_byte_q;
  assign o_Busy    = (state_q != IDLE);
  assign o_Overrun = overrun_q;

endmodule
